// File: rtl/mem_copy_master_pkg.sv
`default_nettype none
// ============================================================================
// mcu_bus_pkg : shared MCU data-bus widths and block-copy FSM state encoding
// Revision    : 1.0
// ============================================================================
package mcu_bus_pkg;

    localparam int MCU_ADDR_W = 32;
    localparam int MCU_DATA_W = 32;
    localparam int MCU_LEN_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_copy_master_if.sv
`default_nettype none
// ============================================================================
// mem_copy_master_if : control handshake plus data-memory bus of the copier
// Revision           : 1.0
// ============================================================================
interface mem_copy_master_if
    import mcu_bus_pkg::*;
#(
    parameter int ADDR_W = MCU_ADDR_W,
    parameter int DATA_W = MCU_DATA_W,
    parameter int LEN_W  = MCU_LEN_W
) ();

    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  start, src_addr, dst_addr, len, mem_rdata,
        output busy, done, err, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output start, src_addr, dst_addr, len, mem_rdata,
        input  busy, done, err, mem_addr, mem_we, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_copy_master_addr_gen.sv
`default_nettype none
// ============================================================================
// mem_copy_addr_gen : captured src/dst bases and word index of a block copy
// Revision          : 1.0
// ============================================================================
module mem_copy_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              load_i,
    input  wire logic [ADDR_W-1:0] src_i,
    input  wire logic [ADDR_W-1:0] dst_i,
    input  wire logic [LEN_W-1:0]  len_i,
    input  wire logic              inc_i,
    output logic      [ADDR_W-1:0] src_addr_o,
    output logic      [ADDR_W-1:0] dst_addr_o,
    output logic                   last_o
);

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  index_q;
    logic [LEN_W-1:0]  index_d;

    always_comb begin
        index_d = index_q;
        if (load_i) begin
            index_d = '0;
        end else if (inc_i) begin
            index_d = index_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            index_q <= '0;
        end else begin
            if (load_i) begin
                src_q <= src_i;
                dst_q <= dst_i;
                len_q <= len_i;
            end
            index_q <= index_d;
        end
    end

    // Address sums wrap modulo 2^ADDR_W by construction.
    assign src_addr_o = src_q + ADDR_W'(index_q);
    assign dst_addr_o = dst_q + ADDR_W'(index_q);
    assign last_o     = ((index_q + LEN_W'(1)) == len_q);

endmodule
`default_nettype wire

// File: rtl/mem_copy_master.sv
`default_nettype none
// ============================================================================
// mem_copy_master : forward word-by-word block copy initiator for data memory
// Option          : MEMCPY_VERIFY_EN adds a read-back compare after each write
// Revision        : 1.0
// ============================================================================
module mem_copy_master
    import mcu_bus_pkg::*;
#(
    parameter int ADDR_W = MCU_ADDR_W,
    parameter int DATA_W = MCU_DATA_W,
    parameter int LEN_W  = MCU_LEN_W
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_copy_master_if.master bus
);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              load;
    logic              inc;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              last;
`ifdef MEMCPY_VERIFY_EN
    logic              err_q;
    logic              err_d;
`endif

    mem_copy_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .src_i      (bus.src_addr),
        .dst_i      (bus.dst_addr),
        .len_i      (bus.len),
        .inc_i      (inc),
        .src_addr_o (src_addr),
        .dst_addr_o (dst_addr),
        .last_o     (last)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        load    = 1'b0;
        inc     = 1'b0;
`ifdef MEMCPY_VERIFY_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
`ifdef MEMCPY_VERIFY_EN
                    err_d   = 1'b0;
`endif
                    state_d = (bus.len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                data_d  = bus.mem_rdata;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
`ifdef MEMCPY_VERIFY_EN
                // Index advances after the read-back so VERIFY reuses dst+index.
                state_d = ST_VERIFY;
`else
                inc     = 1'b1;
                state_d = last ? ST_DONE : ST_READ;
`endif
            end
`ifdef MEMCPY_VERIFY_EN
            ST_VERIFY: begin
                inc = 1'b1;
                if (bus.mem_rdata != data_q) begin
                    err_d = 1'b1;
                end
                state_d = last ? ST_DONE : ST_READ;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

`ifdef MEMCPY_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = (state_q == ST_DONE);
        bus.mem_we    = (state_q == ST_WRITE);
        bus.mem_wdata = (state_q == ST_WRITE) ? data_q : '0;
        case (state_q)
            ST_READ:   bus.mem_addr = src_addr;
            ST_WRITE:  bus.mem_addr = dst_addr;
            ST_VERIFY: bus.mem_addr = dst_addr;
            default:   bus.mem_addr = '0;
        endcase
    end

endmodule
`default_nettype wire
